alarm_buzzer_driver: RTL

- Consumer end of the timer alarm line: takes the level alarm from a countdown timer and drives a piezo buzzer.
- Output is a tone square wave in a beep/pause/gap burst pattern.
- Supports user silence and auto-silence after a burst limit.
- Sits between the timer's alarm output and the board buzzer pin; also exports an activity flag for the LED bar.

---
 rtl/alarm_buzzer_driver.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alarm_buzzer_driver.sv
// rtl/alarm_buzzer_driver.sv - beep/pause/gap burst buzzer driver fed by the timer alarm level.
// Optional macro BUZZER_ESCALATE_EN: from the 8th burst on, the burst gap shrinks to BEEP_OFF_MS.
module alarm_buzzer_driver #(
    parameter int SYS_CLK_HZ   = 100000000,
    parameter int TONE_HZ      = 2000,
    parameter int BEEP_ON_MS   = 100,
    parameter int BEEP_OFF_MS  = 100,
    parameter int BEEP_COUNT   = 4,
    parameter int BURST_GAP_MS = 600,
    parameter int MAX_BURSTS   = 30
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       alarm_in,
    input  logic       silence,
    output logic       buzz_out,
    output logic       active,
    output logic [7:0] burst_cnt
);

    localparam int          CPM       = SYS_CLK_HZ / 1000;
    localparam int          HALF      = SYS_CLK_HZ / (2 * TONE_HZ);
    localparam logic [31:0] ON_LAST   = 32'(BEEP_ON_MS * CPM - 1);
    localparam logic [31:0] OFF_LAST  = 32'(BEEP_OFF_MS * CPM - 1);
    localparam logic [31:0] GAP_LAST  = 32'(BURST_GAP_MS * CPM - 1);
    localparam logic [31:0] HALF_LAST = 32'(HALF - 1);
    localparam logic [31:0] BEEP_LAST = 32'(BEEP_COUNT - 1);
    localparam logic [31:0] MAX_B     = 32'(MAX_BURSTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TONE,
        S_PAUSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t      r_state;
    logic        r_alarm_prev;
    logic [31:0] r_dur;
    logic [31:0] r_tone;
    logic [31:0] r_beep;
    logic [7:0]  r_burst;
    logic        r_buzz;
    logic        r_active;

    state_t      w_state_nxt;
    logic [31:0] w_dur_nxt;
    logic [31:0] w_tone_nxt;
    logic [31:0] w_beep_nxt;
    logic [7:0]  w_burst_nxt;
    logic        w_buzz_nxt;
    logic        w_active_nxt;
    logic        w_rise;
    logic        w_running;
    logic [31:0] w_gap_last;

    assign w_rise    = alarm_in & ~r_alarm_prev;
    assign w_running = (r_state == S_TONE) || (r_state == S_PAUSE) || (r_state == S_GAP);

`ifdef BUZZER_ESCALATE_EN
    assign w_gap_last = (r_burst >= 8'd8) ? OFF_LAST : GAP_LAST;
`else
    assign w_gap_last = GAP_LAST;
`endif

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_state      <= S_IDLE;
            r_alarm_prev <= 1'b0;
            r_dur        <= '0;
            r_tone       <= '0;
            r_beep       <= '0;
            r_burst      <= '0;
            r_buzz       <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_alarm_prev <= alarm_in;
            r_dur        <= w_dur_nxt;
            r_tone       <= w_tone_nxt;
            r_beep       <= w_beep_nxt;
            r_burst      <= w_burst_nxt;
            r_buzz       <= w_buzz_nxt;
            r_active     <= w_active_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beep_nxt  = r_beep;
        w_burst_nxt = r_burst;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_TONE;
                    w_beep_nxt  = '0;
                    w_burst_nxt = '0;
                end
            end
            S_DONE: begin
                if (!alarm_in) w_state_nxt = S_IDLE;
            end
            S_TONE, S_PAUSE, S_GAP: begin
                // Alarm removal outranks silence, which outranks the pattern timing.
                if (!alarm_in) begin
                    w_state_nxt = S_IDLE;
                end else if (silence) begin
                    w_state_nxt = S_DONE;
                end else if (r_state == S_TONE) begin
                    if (r_dur == ON_LAST) begin
                        if (r_beep < BEEP_LAST) begin
                            w_state_nxt = S_PAUSE;
                        end else begin
                            w_state_nxt = S_GAP;
                            w_burst_nxt = (r_burst == 8'hFF) ? r_burst : r_burst + 8'd1;
                        end
                    end
                end else if (r_state == S_PAUSE) begin
                    if (r_dur == OFF_LAST) begin
                        w_state_nxt = S_TONE;
                        w_beep_nxt  = r_beep + 32'd1;
                    end
                end else begin
                    if (r_dur == w_gap_last) begin
                        if ((MAX_B != 32'd0) && (32'(r_burst) == MAX_B)) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_state_nxt = S_TONE;
                            w_beep_nxt  = '0;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Duration counter restarts on every state change so each state lasts exactly D*CPM cycles.
        w_dur_nxt = (w_running && (w_state_nxt == r_state)) ? r_dur + 32'd1 : '0;

        w_buzz_nxt = 1'b0;
        w_tone_nxt = '0;
        if (w_state_nxt == S_TONE) begin
            if (r_state != S_TONE) begin
                w_buzz_nxt = 1'b1;
            end else if (r_tone == HALF_LAST) begin
                w_buzz_nxt = ~r_buzz;
            end else begin
                w_buzz_nxt = r_buzz;
                w_tone_nxt = r_tone + 32'd1;
            end
        end

        w_active_nxt = (w_state_nxt == S_TONE) || (w_state_nxt == S_PAUSE) || (w_state_nxt == S_GAP);
    end

    assign buzz_out  = r_buzz;
    assign active    = r_active;
    assign burst_cnt = r_burst;

endmodule
